// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types for the shared memory port arbiter.
//   - arb_state_e : per-cycle arbitration result (IDLE / GNT_I / GNT_D)
//   - REQ_I/REQ_D : owner encodings used in the response tag
//   - rsp_tag_t   : response tag captured at grant, consumed the next cycle
//   Optional feature macro used by the arbiter: MEM_ARB_RR_EN (round-robin ties).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef struct packed {
    logic owner;
    logic is_read;
  } rsp_tag_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// mem_arb_starve_cnt
//   Saturating count of consecutive D grants while the fetch side waits.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     inc        : count one more D grant that overtook a waiting fetch
//     clr        : clear (fetch granted or no fetch pending); wins over inc
//     sat        : counter has reached MAX_WAIT, fetch must win the next tie
//   Not used when MEM_ARB_RR_EN is defined.
module mem_arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_d, cnt_q;

  // Next count: clear dominates, increment stops at MAX_CNT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous memory port between instruction fetch (I) and
//   load/store (D). At most one access per cycle; read data returns the
//   cycle after the grant, directly from mem_rd, to the owning requester.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     i_req/i_adr                : fetch request, held until i_gnt
//     i_gnt/i_rvalid/i_rdata     : fetch grant pulse, data-valid pulse, data
//     d_req/d_adr/d_wd/d_we      : load/store request, held until d_gnt
//     d_gnt/d_rvalid/d_rdata     : data grant pulse, load-valid pulse, data
//     mem_adr/mem_wd/mem_we      : memory port driven from the winner
//     mem_rd                     : memory read data, one cycle after address
//   Configuration macro MEM_ARB_RR_EN: when defined, ties go to the side not
//   granted last; otherwise D wins ties unless fetch has waited MAX_WAIT grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_adr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_adr,
  input  logic [DATA_WIDTH-1:0] d_wd,
  input  logic                  d_we,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  arb_state_e            state_d, state_q;
  rsp_tag_t              tag_d, tag_q;
  logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;
  logic                  tie_to_i;

`ifdef MEM_ARB_RR_EN
  logic last_d, last_q;

  // Round-robin: on a tie the side that did not win most recently goes next.
  assign tie_to_i = (last_q == REQ_D);

  // Remember the owner of the latest real grant; idle cycles keep it.
  always_comb begin
    last_d = last_q;
    if (state_d == GNT_I) begin
      last_d = REQ_I;
    end else if (state_d == GNT_D) begin
      last_d = REQ_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= REQ_I;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic starve_sat;

  // Counts D grants that overtook a waiting fetch; once saturated the
  // fetch takes the next tie, which also clears the count.
  mem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (d_gnt & i_req),
    .clr   (i_gnt | ~i_req),
    .sat   (starve_sat)
  );

  assign tie_to_i = starve_sat;
`endif

  // Winner select for this cycle. Reset suppresses any grant immediately
  // so nothing reaches memory while reset is held.
  always_comb begin
    state_d = IDLE;
    if (!reset) begin
      if (i_req && d_req) begin
        state_d = tie_to_i ? GNT_I : GNT_D;
      end else if (i_req) begin
        state_d = GNT_I;
      end else if (d_req) begin
        state_d = GNT_D;
      end
    end
  end

  // Grant pulses and memory port mux; an idle port drives zeros.
  always_comb begin
    i_gnt   = (state_d == GNT_I);
    d_gnt   = (state_d == GNT_D);
    mem_adr = '0;
    mem_wd  = '0;
    mem_we  = 1'b0;
    if (state_d == GNT_I) begin
      mem_adr = i_adr;
    end else if (state_d == GNT_D) begin
      mem_adr = d_adr;
      mem_wd  = d_wd;
      mem_we  = d_we;
    end
  end

  // Response tag: who owns next cycle's mem_rd and whether it is a read.
  always_comb begin
    tag_d.owner   = (state_d == GNT_D) ? REQ_D : REQ_I;
    tag_d.is_read = (state_d == GNT_I) || ((state_d == GNT_D) && !d_we);
  end

  // rvalid comes from last cycle's tag; reset in the return cycle drops it.
  assign i_rvalid = !reset && (state_q != IDLE) && tag_q.is_read && (tag_q.owner == REQ_I);
  assign d_rvalid = !reset && (state_q != IDLE) && tag_q.is_read && (tag_q.owner == REQ_D);

  // Read data passes straight through in the return cycle and is held after.
  assign i_rdata = i_rvalid ? mem_rd : i_rdata_q;
  assign d_rdata = d_rvalid ? mem_rd : d_rdata_q;

  // Arbitration state, response tag and held read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tag_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      i_rdata_q <= i_rdata;
      d_rdata_q <= d_rdata;
    end
  end

endmodule
